ble_cmd_rx: RTL

- UART receiver and command authorisation stage.
- Sits directly downstream of the BLE/host UART link on the Segway RX pin and upstream of the balance controller.
- Deserialises 8N1 bytes and tracks the 'g' (go) and 's' (stop) commands.
- Combines those commands with the rider-off status to produce the pwr_up enable.

---
 rtl/ble_cmd_rx.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ble_cmd_rx.sv
// ble_cmd_rx: 8N1 UART receiver and power-up authorisation for the balance controller.
// The 'g' command turns the balance enable on. The 's' command turns it off if nobody
// is standing on the board; otherwise it waits until the rider steps off.
// Optional feature macro: CMD_TIMEOUT_EN. It adds a link-loss timeout in PWR1. When it
// expires, the block acts as if CMD_STOP had been received.
module ble_cmd_rx #(
   parameter int          BAUD_DIV = 2604,
   parameter logic [7:0]  CMD_GO   = 8'h67,
   parameter logic [7:0]  CMD_STOP = 8'h73,
   parameter int          TMO_CYC  = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       rider_off,
   output logic [7:0] rx_data,
   output logic       rx_rdy,
   output logic       frm_err,
   output logic       pwr_up
);

   localparam int            CW   = $clog2(BAUD_DIV + 1);
   localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
   localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} rx_state_t;
   typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

   logic          rx_meta;
   logic          rx_s;
   rx_state_t     rx_state;
   logic [CW-1:0] baud_cnt;
   logic [3:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic          baud_exp;
   auth_state_t   auth_state;
   logic          got_go;
   logic          got_stop;
   logic          tmo_hit;
   logic          stop_req;

   // Two-flop synchroniser. It resets to the idle (high) level, so a reset release never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
      end
   end

   // The counter counts down to 1, so a load of N gives the sample point exactly N clocks later.
   assign baud_exp = (baud_cnt == CW'(1));

   // Receive FSM: detect the start bit, then sample every bit at its midpoint.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state  <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= 4'd0;
         shift_reg <= 8'h00;
         rx_data   <= 8'h00;
         rx_rdy    <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         rx_rdy  <= 1'b0;
         frm_err <= 1'b0;
         case (rx_state)
            IDLE: begin
               if (!rx_s) begin
                  rx_state <= START;
                  baud_cnt <= HALF;
               end
            end
            START: begin
               if (baud_exp) begin
                  if (rx_s) begin
                     rx_state <= IDLE;
                  end else begin
                     rx_state <= DATA;
                     baud_cnt <= FULL;
                     bit_idx  <= 4'd0;
                  end
               end else begin
                  baud_cnt <= baud_cnt - CW'(1);
               end
            end
            DATA: begin
               if (baud_exp) begin
                  shift_reg <= {rx_s, shift_reg[7:1]};
                  baud_cnt  <= FULL;
                  if (bit_idx == 4'd7) begin
                     rx_state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - CW'(1);
               end
            end
            STOP: begin
               if (baud_exp) begin
                  if (rx_s) begin
                     rx_data  <= shift_reg;
                     rx_rdy   <= 1'b1;
                     rx_state <= IDLE;
                  end else begin
                     frm_err  <= 1'b1;
                     rx_state <= WAIT_HI;
                  end
               end else begin
                  baud_cnt <= baud_cnt - CW'(1);
               end
            end
            WAIT_HI: begin
               // A held break must not be taken as a new start bit.
               if (rx_s) begin
                  rx_state <= IDLE;
               end
            end
            default: rx_state <= IDLE;
         endcase
      end
   end

   assign got_go   = rx_rdy && (rx_data == CMD_GO);
   assign got_stop = rx_rdy && (rx_data == CMD_STOP);

`ifdef CMD_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYC + 1);
   logic [TW-1:0] tmo_cnt;

   assign tmo_hit = (auth_state == PWR1) && (tmo_cnt == TW'(TMO_CYC));

   // Link-loss counter. It runs only in PWR1 and restarts on any received byte.
   // It also clears when the timeout fires, because the timeout always leaves PWR1.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if ((auth_state != PWR1) || rx_rdy || tmo_hit) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   assign stop_req = got_stop || tmo_hit;

   // Authorisation FSM. pwr_up is loaded with the next state, so it follows the state change with no extra delay.
   always_ff @(posedge clk) begin
      if (rst) begin
         auth_state <= OFF;
         pwr_up     <= 1'b0;
      end else begin
         case (auth_state)
            OFF: begin
               if (got_go) begin
                  auth_state <= PWR1;
                  pwr_up     <= 1'b1;
               end
            end
            PWR1: begin
               if (stop_req) begin
                  if (rider_off) begin
                     auth_state <= OFF;
                     pwr_up     <= 1'b0;
                  end else begin
                     auth_state <= PWR2;
                     pwr_up     <= 1'b1;
                  end
               end
            end
            PWR2: begin
               // rider_off has priority over a GO byte in the same cycle.
               if (rider_off) begin
                  auth_state <= OFF;
                  pwr_up     <= 1'b0;
               end else if (got_go) begin
                  auth_state <= PWR1;
                  pwr_up     <= 1'b1;
               end
            end
            default: begin
               auth_state <= OFF;
               pwr_up     <= 1'b0;
            end
         endcase
      end
   end

endmodule
